npu_traffic_gen: RTL and testbench

NPU_TRAFFIC_GEN -- requirements
Module: npu_traffic_gen

---
 rtl/npu_traffic_gen.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_npu_traffic_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_traffic_gen.sv
// npu_traffic_gen
//   Header traffic generator for exercising a packet-processing NPU stage.
//   A run starts on a 'start' pulse. The block sends NUM_PKTS headers whose
//   srcAddr carries the packet sequence number. After each accepted header it
//   can insert GAP idle cycles. It then checks every header that comes back:
//   the ttl must be one less than the ttl that was sent, srcAddr must arrive
//   in order, and no header may come back that was never sent. 'err' is
//   sticky for the whole run. 'done' is a level that stays high until the
//   next 'start'.
//
//   Optional feature: define TRAFFIC_GEN_PCOUNT_EN to add a performance-
//   counter query port (io_pcIn_* / io_pcOut_*) and a stall counter.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   start                      pulse: begin a run (from IDLE), or rearm (from DONE)
//   done, err                  run finished, sticky return-check error
//   io_out_*                   outgoing header stream (valid/ready)
//   io_in_*                    returned header stream (valid/ready)
//   sent_count, recv_count     accepted sends / returns in the current run
//   io_pcIn_*, io_pcOut_*      counter query/response (TRAFFIC_GEN_PCOUNT_EN only)

module npu_traffic_gen #(
  parameter int NUM_PKTS = 32'sd16,
  parameter int TTL_INIT = 32'sd3,
  parameter int L2_PROTO = 32'sd128,
  parameter int L3_TYPE  = 32'sd64,
  parameter int GAP      = 32'sd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        err,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [7:0]  io_out_bits_l2Protocol,
  output logic [7:0]  io_out_bits_eth_l3Type,
  output logic [7:0]  io_out_bits_ipv4_ttl,
  output logic [31:0] io_out_bits_ipv4_srcAddr,
  input  logic        io_in_valid,
  output logic        io_in_ready,
  input  logic [7:0]  io_in_bits_ipv4_ttl,
  input  logic [31:0] io_in_bits_ipv4_srcAddr,
`ifdef TRAFFIC_GEN_PCOUNT_EN
  input  logic        io_pcIn_valid,
  input  logic        io_pcIn_bits_request,
  input  logic [15:0] io_pcIn_bits_moduleId,
  input  logic [7:0]  io_pcIn_bits_portId,
  input  logic [3:0]  io_pcIn_bits_pcType,
  output logic        io_pcOut_valid,
  output logic        io_pcOut_bits_request,
  output logic [15:0] io_pcOut_bits_moduleId,
  output logic [7:0]  io_pcOut_bits_portId,
  output logic [15:0] io_pcOut_bits_pcValue,
  output logic [3:0]  io_pcOut_bits_pcType,
`endif
  output logic [15:0] sent_count,
  output logic [15:0] recv_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] NUM_PKTS_C = 16'(NUM_PKTS);
  localparam logic [15:0] LAST_IDX_C = 16'(NUM_PKTS - 32'sd1);
  localparam logic [7:0]  GAP_C      = 8'(GAP);
  localparam logic [7:0]  TTL_C      = 8'(TTL_INIT);
  // A TTL_INIT of 1 expects 0 back; the plain 8-bit subtract gives that directly.
  localparam logic [7:0]  TTL_EXP_C  = 8'(TTL_INIT - 32'sd1);
  localparam logic [7:0]  L2_C       = 8'(L2_PROTO);
  localparam logic [7:0]  L3_C       = 8'(L3_TYPE);

  // A returned header is wrong if its ttl was not decremented exactly once,
  // if it is out of order, or if nothing is outstanding (unsolicited).
  function automatic logic beat_mismatch(input logic [7:0]  ttl,
                                         input logic [31:0] src,
                                         input logic [15:0] recv,
                                         input logic [15:0] sent);
    beat_mismatch = (ttl != TTL_EXP_C) ||
                    (src != {16'h0000, recv}) ||
                    (recv == sent);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] sent_cnt_r, sent_nxt_s;
  logic [15:0] recv_cnt_r, recv_nxt_s;
  logic [7:0]  gap_cnt_r, gap_nxt_s;
  logic        err_r, err_nxt_s;
  logic        cnt_clr_s;

  logic        out_valid_r;
  logic        in_ready_r;
  logic        done_r;
  logic [7:0]  l2_r, l3_r, ttl_r;
  logic [31:0] src_r;

  logic        out_accept_s;
  logic        in_beat_s;

  assign out_accept_s = out_valid_r && io_out_ready;
  assign in_beat_s    = io_in_valid && in_ready_r;

  // Next-state, counter and sticky-error logic.
  always_comb begin
    state_nxt_s = state_r;
    sent_nxt_s  = sent_cnt_r;
    recv_nxt_s  = recv_cnt_r;
    gap_nxt_s   = gap_cnt_r;
    err_nxt_s   = err_r;
    cnt_clr_s   = 1'b0;

    // Returns are checked in any state that has io_in_ready high. A send and a
    // return in the same cycle update their own counters independently.
    if (in_beat_s) begin
      recv_nxt_s = recv_cnt_r + 16'd1;
      if (beat_mismatch(io_in_bits_ipv4_ttl, io_in_bits_ipv4_srcAddr,
                        recv_cnt_r, sent_cnt_r)) begin
        err_nxt_s = 1'b1;
      end else begin
        err_nxt_s = err_r;
      end
    end else begin
      recv_nxt_s = recv_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SEND;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (out_accept_s) begin
          sent_nxt_s = sent_cnt_r + 16'd1;
          if (sent_cnt_r == LAST_IDX_C) begin
            state_nxt_s = ST_DRAIN;
          end else if (GAP_C != 8'd0) begin
            state_nxt_s = ST_GAP;
            // GAP idle cycles: counting down from GAP-1 to 0 covers exactly GAP cycles.
            gap_nxt_s   = GAP_C - 8'd1;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_GAP: begin
        if (gap_cnt_r == 8'd0) begin
          state_nxt_s = ST_SEND;
        end else begin
          gap_nxt_s   = gap_cnt_r - 8'd1;
          state_nxt_s = ST_GAP;
        end
      end
      ST_DRAIN: begin
        // Uses >= so a stray extra return cannot leave the run stuck in DRAIN.
        if (recv_cnt_r >= NUM_PKTS_C) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_IDLE;
          cnt_clr_s   = 1'b1;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_clr_s   = 1'b1;
      end
    endcase

    if (cnt_clr_s) begin
      sent_nxt_s = 16'd0;
      recv_nxt_s = 16'd0;
      err_nxt_s  = 1'b0;
    end else begin
      sent_nxt_s = sent_nxt_s;
    end
  end

  // State, counters and registered outputs. The outputs are decoded from the
  // next state, so they line up with the state register without extra delay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      sent_cnt_r  <= 16'd0;
      recv_cnt_r  <= 16'd0;
      gap_cnt_r   <= 8'd0;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      done_r      <= 1'b0;
      l2_r        <= 8'd0;
      l3_r        <= 8'd0;
      ttl_r       <= 8'd0;
      src_r       <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      sent_cnt_r  <= sent_nxt_s;
      recv_cnt_r  <= recv_nxt_s;
      gap_cnt_r   <= gap_nxt_s;
      err_r       <= err_nxt_s;
      out_valid_r <= (state_nxt_s == ST_SEND);
      in_ready_r  <= (state_nxt_s == ST_SEND) || (state_nxt_s == ST_GAP) ||
                     (state_nxt_s == ST_DRAIN);
      done_r      <= (state_nxt_s == ST_DONE);
      // The header stays stable while stalled because sent_count only moves on accept.
      if (state_nxt_s == ST_SEND) begin
        l2_r  <= L2_C;
        l3_r  <= L3_C;
        ttl_r <= TTL_C;
        src_r <= {16'h0000, sent_nxt_s};
      end else begin
        l2_r  <= 8'd0;
        l3_r  <= 8'd0;
        ttl_r <= 8'd0;
        src_r <= 32'd0;
      end
    end
  end

  assign done                     = done_r;
  assign err                      = err_r;
  assign io_out_valid             = out_valid_r;
  assign io_in_ready              = in_ready_r;
  assign io_out_bits_l2Protocol   = l2_r;
  assign io_out_bits_eth_l3Type   = l3_r;
  assign io_out_bits_ipv4_ttl     = ttl_r;
  assign io_out_bits_ipv4_srcAddr = src_r;
  assign sent_count               = sent_cnt_r;
  assign recv_count               = recv_cnt_r;

`ifdef TRAFFIC_GEN_PCOUNT_EN
  logic [15:0] stall_cnt_r;
  logic        pc_valid_r, pc_req_r;
  logic [15:0] pc_mod_r, pc_val_r;
  logic [7:0]  pc_port_r;
  logic [3:0]  pc_type_r;
  logic        pc_hit_s;

  // Only requests addressed to module 0 are answered here; everything else passes through.
  assign pc_hit_s = io_pcIn_valid && io_pcIn_bits_request &&
                    (io_pcIn_bits_moduleId == 16'h0000);

  function automatic logic [15:0] pc_value_sel(input logic [3:0]  pc_type,
                                               input logic [15:0] sent,
                                               input logic [15:0] recv,
                                               input logic [15:0] stall);
    case (pc_type)
      4'd0:    pc_value_sel = sent;
      4'd1:    pc_value_sel = recv;
      4'd2:    pc_value_sel = stall;
      default: pc_value_sel = 16'h0000;
    endcase
  endfunction

  // Stall counter (offered but not accepted in SEND) and the query response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
      pc_valid_r  <= 1'b0;
      pc_req_r    <= 1'b0;
      pc_mod_r    <= 16'd0;
      pc_port_r   <= 8'd0;
      pc_type_r   <= 4'd0;
      pc_val_r    <= 16'd0;
    end else begin
      if (cnt_clr_s) begin
        stall_cnt_r <= 16'd0;
      end else if ((state_r == ST_SEND) && out_valid_r && !io_out_ready) begin
        stall_cnt_r <= stall_cnt_r + 16'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      pc_valid_r <= io_pcIn_valid;
      pc_mod_r   <= io_pcIn_bits_moduleId;
      pc_port_r  <= io_pcIn_bits_portId;
      pc_type_r  <= io_pcIn_bits_pcType;
      if (pc_hit_s) begin
        pc_req_r <= 1'b0;
        pc_val_r <= pc_value_sel(io_pcIn_bits_pcType, sent_cnt_r, recv_cnt_r, stall_cnt_r);
      end else begin
        pc_req_r <= io_pcIn_bits_request;
        pc_val_r <= 16'd0;
      end
    end
  end

  assign io_pcOut_valid         = pc_valid_r;
  assign io_pcOut_bits_request  = pc_req_r;
  assign io_pcOut_bits_moduleId = pc_mod_r;
  assign io_pcOut_bits_portId   = pc_port_r;
  assign io_pcOut_bits_pcValue  = pc_val_r;
  assign io_pcOut_bits_pcType   = pc_type_r;
`endif

endmodule

// File: tb/tb_npu_traffic_gen.sv
// Bench for npu_traffic_gen: a loopback responder returns every accepted header
// with ttl-1. A scoreboard queue holds the expected srcAddr sequence and a monitor
// compares every offered header against it.
module tb_npu_traffic_gen;

  logic        clk = 1'b0;
  logic        reset, start, done, err;
  logic        io_out_valid, io_out_ready;
  logic [7:0]  io_out_bits_l2Protocol, io_out_bits_eth_l3Type, io_out_bits_ipv4_ttl;
  logic [31:0] io_out_bits_ipv4_srcAddr;
  logic        io_in_valid, io_in_ready;
  logic [7:0]  io_in_bits_ipv4_ttl;
  logic [31:0] io_in_bits_ipv4_srcAddr;
  logic [15:0] sent_count, recv_count;

  logic        g_done, g_err, g_out_valid, g_in_ready;
  logic [7:0]  g_l2, g_l3, g_ttl;
  logic [31:0] g_src;
  logic [15:0] g_sent, g_recv;

`ifdef TRAFFIC_GEN_PCOUNT_EN
  logic        pc_in_valid, pc_in_req, pc_out_valid, pc_out_req;
  logic [15:0] pc_in_mod, pc_out_mod, pc_out_val;
  logic [7:0]  pc_in_port, pc_out_port;
  logic [3:0]  pc_in_type, pc_out_type;
  logic        gp_out_valid, gp_out_req;
  logic [15:0] gp_out_mod, gp_out_val;
  logic [7:0]  gp_out_port;
  logic [3:0]  gp_out_type;
`endif

  always #5 clk = ~clk;

  npu_traffic_gen #(.NUM_PKTS(16), .TTL_INIT(3), .L2_PROTO(128), .L3_TYPE(64), .GAP(0)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .err(err),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_l2Protocol(io_out_bits_l2Protocol),
    .io_out_bits_eth_l3Type(io_out_bits_eth_l3Type),
    .io_out_bits_ipv4_ttl(io_out_bits_ipv4_ttl),
    .io_out_bits_ipv4_srcAddr(io_out_bits_ipv4_srcAddr),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_ipv4_ttl(io_in_bits_ipv4_ttl),
    .io_in_bits_ipv4_srcAddr(io_in_bits_ipv4_srcAddr),
`ifdef TRAFFIC_GEN_PCOUNT_EN
    .io_pcIn_valid(pc_in_valid), .io_pcIn_bits_request(pc_in_req),
    .io_pcIn_bits_moduleId(pc_in_mod), .io_pcIn_bits_portId(pc_in_port),
    .io_pcIn_bits_pcType(pc_in_type),
    .io_pcOut_valid(pc_out_valid), .io_pcOut_bits_request(pc_out_req),
    .io_pcOut_bits_moduleId(pc_out_mod), .io_pcOut_bits_portId(pc_out_port),
    .io_pcOut_bits_pcValue(pc_out_val), .io_pcOut_bits_pcType(pc_out_type),
`endif
    .sent_count(sent_count), .recv_count(recv_count)
  );

  // Second instance with GAP=2, used only to measure accept-to-next-valid spacing.
  npu_traffic_gen #(.NUM_PKTS(4), .TTL_INIT(3), .L2_PROTO(128), .L3_TYPE(64), .GAP(2)) dut_gap (
    .clk(clk), .reset(reset), .start(start), .done(g_done), .err(g_err),
    .io_out_valid(g_out_valid), .io_out_ready(1'b1),
    .io_out_bits_l2Protocol(g_l2), .io_out_bits_eth_l3Type(g_l3),
    .io_out_bits_ipv4_ttl(g_ttl), .io_out_bits_ipv4_srcAddr(g_src),
    .io_in_valid(1'b0), .io_in_ready(g_in_ready),
    .io_in_bits_ipv4_ttl(8'd0), .io_in_bits_ipv4_srcAddr(32'd0),
`ifdef TRAFFIC_GEN_PCOUNT_EN
    .io_pcIn_valid(1'b0), .io_pcIn_bits_request(1'b0),
    .io_pcIn_bits_moduleId(16'd0), .io_pcIn_bits_portId(8'd0),
    .io_pcIn_bits_pcType(4'd0),
    .io_pcOut_valid(gp_out_valid), .io_pcOut_bits_request(gp_out_req),
    .io_pcOut_bits_moduleId(gp_out_mod), .io_pcOut_bits_portId(gp_out_port),
    .io_pcOut_bits_pcValue(gp_out_val), .io_pcOut_bits_pcType(gp_out_type),
`endif
    .sent_count(g_sent), .recv_count(g_recv)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        corrupt_en = 1'b0;
  logic        rsp_acc;
  logic [31:0] rsp_src;
  logic [7:0]  rsp_ttl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(i));
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 400; k++) begin
      if (done) break;
      tick();
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, 32'(io_out_valid), 32'd0);
    chk({tag, "_in_ready"},  32'(io_in_ready), 32'd0);
    chk({tag, "_done"},      32'(done), 32'd0);
    chk({tag, "_err"},       32'(err), 32'd0);
    chk({tag, "_sent"},      32'(sent_count), 32'd0);
    chk({tag, "_recv"},      32'(recv_count), 32'd0);
    chk({tag, "_l2"},        32'(io_out_bits_l2Protocol), 32'd0);
    chk({tag, "_l3"},        32'(io_out_bits_eth_l3Type), 32'd0);
    chk({tag, "_ttl"},       32'(io_out_bits_ipv4_ttl), 32'd0);
    chk({tag, "_src"},       io_out_bits_ipv4_srcAddr, 32'd0);
  endtask

  // Monitor: every offered header must match the scoreboard head; pop on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (io_out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_empty: srcAddr %0d offered, expected no send", io_out_bits_ipv4_srcAddr);
        end else begin
          chk("hdr_src", io_out_bits_ipv4_srcAddr, exp_q[0]);
          chk("hdr_ttl", 32'(io_out_bits_ipv4_ttl), 32'd3);
          chk("hdr_l2",  32'(io_out_bits_l2Protocol), 32'd128);
          chk("hdr_l3",  32'(io_out_bits_eth_l3Type), 32'd64);
          if (io_out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Loopback responder: returns each accepted header one cycle later with ttl-1,
  // or with the ttl left unchanged on packet 5 when corrupt_en is set.
  initial begin
    io_in_valid = 1'b0;
    io_in_bits_ipv4_ttl = 8'd0;
    io_in_bits_ipv4_srcAddr = 32'd0;
    forever begin
      @(negedge clk);
      rsp_acc = io_out_valid && io_out_ready;
      rsp_src = io_out_bits_ipv4_srcAddr;
      rsp_ttl = io_out_bits_ipv4_ttl;
      @(posedge clk);
      #1;
      io_in_valid = rsp_acc;
      io_in_bits_ipv4_srcAddr = rsp_src;
      io_in_bits_ipv4_ttl = (corrupt_en && rsp_src == 32'd5) ? rsp_ttl : rsp_ttl - 8'd1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v_cnt, v_last;
    int g_times[$];
    reset = 1'b1;
    start = 1'b0;
    io_out_ready = 1'b0;
`ifdef TRAFFIC_GEN_PCOUNT_EN
    pc_in_valid = 1'b0; pc_in_req = 1'b0; pc_in_mod = 16'd0;
    pc_in_port = 8'd0; pc_in_type = 4'd0;
`endif
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // Loopback at full rate, with the GAP=2 instance running alongside.
    push_run();
    io_out_ready = 1'b1;
    pulse_start();
    chk("send_in_ready", 32'(io_in_ready), 32'd1);
    v_cnt = 0;
    v_last = -1;
    for (int n = 0; n < 20; n++) begin
      if (io_out_valid) begin v_cnt++; v_last = n; end
      if (g_out_valid) g_times.push_back(n);
      tick();
    end
    chk("consec_cnt", 32'(v_cnt), 32'd16);
    chk("consec_last", 32'(v_last), 32'd15);
    chk("gap_nvalid", 32'(g_times.size()), 32'd4);
    if (g_times.size() == 4) begin
      chk("gap_first", 32'(g_times[0]), 32'd0);
      for (int i = 1; i < 4; i++) chk("gap_spacing", 32'(g_times[i] - g_times[i-1]), 32'd3);
    end
    wait_done("loop_done");
    chk("loop_err", 32'(err), 32'd0);
    chk("loop_sent", 32'(sent_count), 32'd16);
    chk("loop_recv", 32'(recv_count), 32'd16);
    chk("done_in_ready", 32'(io_in_ready), 32'd0);

    // Backpressure: ready high one cycle in three.
    pulse_start();
    chk("rearm_sent", 32'(sent_count), 32'd0);
    chk("rearm_recv", 32'(recv_count), 32'd0);
    chk("rearm_done", 32'(done), 32'd0);
    push_run();
    io_out_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 300; c++) begin
      if (done) break;
      io_out_ready = (c % 3 == 2);
      tick();
    end
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_err", 32'(err), 32'd0);
    chk("bp_recv", 32'(recv_count), 32'd16);
    chk("bp_sb_left", 32'(exp_q.size()), 32'd0);
    io_out_ready = 1'b1;

    // Wrong ttl returned on packet 5.
    pulse_start();
    push_run();
    corrupt_en = 1'b1;
    pulse_start();
    wait_done("ttl_done");
    chk("ttl_err", 32'(err), 32'd1);
    chk("ttl_recv", 32'(recv_count), 32'd16);
    corrupt_en = 1'b0;

    // Reset in the middle of a run, then a fresh run from srcAddr 0.
    pulse_start();
    push_run();
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (sent_count == 16'd7) break;
      tick();
    end
    chk("reach7", 32'(sent_count), 32'd7);
    reset = 1'b1;
    io_out_ready = 1'b0;
    tick();
    chk_reset_vals("midrst");
    exp_q.delete();
    reset = 1'b0;
    io_out_ready = 1'b1;
    tick();
    push_run();
    pulse_start();
    wait_done("fresh_done");
    chk("fresh_err", 32'(err), 32'd0);
    chk("fresh_sent", 32'(sent_count), 32'd16);

`ifdef TRAFFIC_GEN_PCOUNT_EN
    // Counter query after four sends.
    pulse_start();
    push_run();
    pulse_start();
    for (int k = 0; k < 50; k++) begin
      if (sent_count == 16'd4) break;
      tick();
    end
    io_out_ready = 1'b0;
    pc_in_valid = 1'b1; pc_in_req = 1'b1; pc_in_mod = 16'd0;
    pc_in_port = 8'h5A; pc_in_type = 4'd0;
    tick();
    pc_in_valid = 1'b0; pc_in_req = 1'b0;
    chk("pc_valid", 32'(pc_out_valid), 32'd1);
    chk("pc_req", 32'(pc_out_req), 32'd0);
    chk("pc_value", 32'(pc_out_val), 32'd4);
    chk("pc_port", 32'(pc_out_port), 32'h5A);
    io_out_ready = 1'b1;
    wait_done("pc_done");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
